// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the unified-memory arbiter.
// Holds the FSM state encoding, the port index constants and the default widths.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // A grant vector bit position doubles as the last-grant register value.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational winner select between the fetch and data ports.
// last_gnt names the port served most recently; on a tie the other port wins.
// Tying last_gnt to PORT_I gives fixed data-over-fetch priority.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_valid,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    logic d_wins;

    // One-hot grant: data wins alone, or on a tie when fetch was served last.
    always_comb begin
        gnt    = '0;
        d_wins = dm_valid && (!if_req || (last_gnt == PORT_I));
        gnt[PORT_D] = d_wins;
        gnt[PORT_I] = if_req && !d_wins;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data requests onto the single-ported memory.
// Memory-side signals are registered and held until mem_done; completion is
// returned to the owning port combinationally in the mem_done cycle.
// Optional macro MEM_ARB_RR_EN: round-robin on ties via a last-grant register;
// without it the data port always wins a tie.
//
// state | meaning
// IDLE  | no transaction; requests evaluated, misaligned data access answered
// GNT_I | fetch access in flight, mem_* held until mem_done
// GNT_D | data access in flight, mem_* held until mem_done
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    output logic          dm_err,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done
);

    arb_state_t state;
    logic       dm_misal;
    logic       dm_valid;
    logic       last_gnt;
    logic [1:0] gnt;
    logic       grant_issue;
    logic       i_fin;
    logic       d_fin;

    assign dm_misal    = dm_req & dm_addr[0];
    assign dm_valid    = dm_req & ~dm_addr[0];
    // A misaligned data request is answered in IDLE and blocks any grant that cycle.
    assign grant_issue = (state == IDLE) && !dm_misal && (gnt != 2'b00);

    mem_arb_grant u_grant (
        .if_req   (if_req),
        .dm_valid (dm_valid),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

`ifdef MEM_ARB_RR_EN
    // Last-grant register; resets to fetch so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= PORT_I;
        end else if (grant_issue) begin
            last_gnt <= gnt[PORT_D] ? PORT_D : PORT_I;
        end
    end
`else
    assign last_gnt = PORT_I;
`endif

    // Arbiter FSM with registered memory-side request, held until mem_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_issue) begin
                        mem_req <= 1'b1;
                        if (gnt[PORT_D]) begin
                            mem_wr    <= dm_wr;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            state     <= GNT_D;
                        end else begin
                            mem_wr    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            state     <= GNT_I;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign i_fin    = (state == GNT_I) && mem_done;
    assign d_fin    = (state == GNT_D) && mem_done;

    assign if_done  = i_fin;
    assign if_rdata = i_fin ? mem_rdata : '0;
    assign if_stall = if_req & ~if_done;

    assign dm_err   = (state == IDLE) && dm_misal;
    assign dm_done  = d_fin || dm_err;
    assign dm_rdata = d_fin ? mem_rdata : '0;
    assign dm_stall = dm_req & ~dm_done;

endmodule
